shift_add_multiplier: RTL and testbench

- Sequential multiply-accumulate that computes product = multiplicand * multiplier + addend. One multiplier bit is processed per clock.
- It is the inverse of the iterative divider. Feeding it quotient, divisor and remainder rebuilds the dividend, so the team uses it for divider self-checks and in arithmetic datapaths that cannot afford a single-cycle multiplier.
- Operands enter through a start/busy/done handshake. The result includes an overflow flag, matching the factorial and average blocks.

---
 rtl/mult_pkg.sv | 12 +
 rtl/shift_add_multiplier.sv | 85 ++++++++
 tb/tb_shift_add_multiplier.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiply-accumulate.
package mult_pkg;

   localparam int MULT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// product = multiplicand * multiplier + addend, one multiplier bit per clk; done WIDTH edges after accept.
// start is ignored while busy; back-to-back ops are accepted from DONE, giving one op per WIDTH+1 cycles.
module shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   input  logic [WIDTH-1:0] addend,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic             overflow
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   mult_state_t        state;
   logic [2*WIDTH-1:0] a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [CNT_W-1:0]   cnt;

   // 2*WIDTH accumulator cannot wrap: (2^W-1)^2 + (2^W-1) < 2^(2W).
   always_comb begin
      acc_next = acc;
      if (b_reg[0]) begin
         acc_next = acc + a_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_reg    <= '0;
         b_reg    <= '0;
         acc      <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         product  <= '0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_reg <= {{WIDTH{1'b0}}, multiplicand};
                  b_reg <= multiplier;
                  acc   <= {{WIDTH{1'b0}}, addend};
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               acc   <= acc_next;
               a_reg <= a_reg << 1;
               b_reg <= b_reg >> 1;
               cnt   <= cnt + CNT_W'(1);
               // Fixed latency: no early exit once the remaining multiplier bits are zero.
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  product  <= acc_next[WIDTH-1:0];
                  overflow <= |acc_next[2*WIDTH-1:WIDTH];
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: directed and randomised multiply-accumulate cases against a 64-bit arithmetic model.
module tb_shift_add_multiplier;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] multiplicand;
   logic [W-1:0] multiplier;
   logic [W-1:0] addend;
   logic         busy;
   logic         done;
   logic [W-1:0] product;
   logic         overflow;

   int n_vec  = 0;
   int n_miss = 0;

   shift_add_multiplier #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .addend       (addend),
      .busy         (busy),
      .done         (done),
      .product      (product),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c);
      return 64'(a) * 64'(b) + 64'(c);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Launch one op, wait for done, check latency/result. glitch_at >= 1 re-pulses start with
   // different operands at that RUN cycle; watch_extra counts any spurious done afterwards.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input int glitch_at, input bit watch_extra);
      logic [63:0] full;
      int lat;
      int busy_low;
      int extra;
      full = model(a, b, c);
      @(negedge clk);
      start = 1'b1;
      multiplicand = a;
      multiplier = b;
      addend = c;
      @(posedge clk);
      #1;
      start = 1'b0;
      multiplicand = $urandom;
      multiplier = $urandom;
      addend = $urandom;
      check({tag, ".busy_on_accept"}, 64'(busy), 64'd1);
      lat = -1;
      busy_low = 0;
      for (int k = 1; k <= W + 8; k++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (k == glitch_at) begin
            start = 1'b1;
            multiplicand = ~a;
            multiplier = ~b;
            addend = c + 1;
         end
         if (done) begin
            lat = k;
            break;
         end
         if (!busy) busy_low++;
      end
      start = 1'b0;
      check({tag, ".latency"}, 64'(lat), 64'(W));
      check({tag, ".busy_held"}, 64'(busy_low), 64'd0);
      check({tag, ".product"}, 64'(product), 64'(full[W-1:0]));
      check({tag, ".overflow"}, 64'(overflow), 64'(|full[63:W]));
      @(posedge clk);
      #1;
      check({tag, ".done_drops"}, 64'(done), 64'd0);
      if (watch_extra) begin
         extra = 0;
         for (int k = 0; k < W + 8; k++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
         end
         check({tag, ".no_extra_done"}, 64'(extra), 64'd0);
         check({tag, ".product_hold"}, 64'(product), 64'(full[W-1:0]));
      end
   endtask

   initial begin
      logic [63:0] f1;
      logic [63:0] f2;
      logic [W-1:0] ra, rb, rc;
      int t1, t2, cyc, cnt_done;

      rst_n = 1'b0;
      start = 1'b0;
      multiplicand = '0;
      multiplier = '0;
      addend = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset.busy", 64'(busy), 64'd0);
      check("reset.done", 64'(done), 64'd0);
      check("reset.product", 64'(product), 64'd0);
      check("reset.overflow", 64'(overflow), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("basic", 32'd7, 32'd6, 32'd0, -1, 1'b0);
      run_op("div_inverse", 32'd14, 32'd7, 32'd2, -1, 1'b0);
      run_op("ovf_2p32", 32'h0001_0000, 32'h0001_0000, 32'd0, -1, 1'b0);
      run_op("ovf_max_plus1", 32'hFFFF_FFFF, 32'd1, 32'd1, -1, 1'b0);
      run_op("max_no_ovf", 32'hFFFF_FFFF, 32'd1, 32'd0, -1, 1'b0);
      run_op("full_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
      run_op("glitch_start", 32'd123457, 32'd98765, 32'd11, 10, 1'b1);

      // start held high through DONE: second op accepted on the edge after the first done.
      f1 = model(32'd1000, 32'd3000, 32'd7);
      f2 = model(32'hDEAD_BEEF, 32'h1234_5678, 32'd99);
      @(negedge clk);
      start = 1'b1;
      multiplicand = 32'd1000;
      multiplier = 32'd3000;
      addend = 32'd7;
      @(posedge clk);
      #1;
      multiplicand = 32'hDEAD_BEEF;
      multiplier = 32'h1234_5678;
      addend = 32'd99;
      t1 = -1;
      t2 = -1;
      cnt_done = 0;
      for (cyc = 1; cyc <= 2 * W + 10; cyc++) begin
         @(posedge clk);
         #1;
         if (done) begin
            cnt_done++;
            if (t1 < 0) begin
               t1 = cyc;
               check("b2b.first_product", 64'(product), 64'(f1[W-1:0]));
            end else begin
               t2 = cyc;
               start = 1'b0;
               check("b2b.second_product", 64'(product), 64'(f2[W-1:0]));
               check("b2b.second_overflow", 64'(overflow), 64'(|f2[63:W]));
               break;
            end
         end else if (t1 > 0 && cyc > t1 + 1) begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check("b2b.first_latency", 64'(t1), 64'(W));
      check("b2b.gap", 64'(t2 - t1), 64'(W + 1));
      check("b2b.done_count", 64'(cnt_done), 64'd2);
      repeat (2) @(posedge clk);

      // Reset at RUN cycle 15 aborts the operation.
      @(negedge clk);
      start = 1'b1;
      multiplicand = 32'd55555;
      multiplier = 32'd77777;
      addend = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("abort.busy", 64'(busy), 64'd0);
      check("abort.done", 64'(done), 64'd0);
      check("abort.product", 64'(product), 64'd0);
      check("abort.overflow", 64'(overflow), 64'd0);
      cnt_done = 0;
      for (int k = 0; k < W + 8; k++) begin
         @(posedge clk);
         #1;
         if (done) cnt_done++;
      end
      check("abort.no_done", 64'(cnt_done), 64'd0);
      run_op("after_abort", 32'd3, 32'd0, 32'd5, -1, 1'b0);

      for (int i = 0; i < 200; i++) begin
         ra = (i % 4 == 0) ? W'($urandom_range(0, 65535)) : W'($urandom);
         rb = (i % 4 == 1) ? W'($urandom_range(0, 255)) : W'($urandom);
         rc = (rb == 0) ? '0 : W'($urandom % rb);
         run_op($sformatf("rand%0d", i), ra, rb, rc, -1, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
